// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input_conditioner block.
package input_cond_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_PRESSED = 2'd1,
    HS_HELD    = 2'd2
  } hold_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One input channel: synchroniser, debounce, edge pulses and hold/repeat FSM.
// Auto-repeat is built only when INPUT_COND_AUTO_REPEAT_EN is defined.
module input_conditioner_ch
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic repeat_o
);

  localparam int unsigned DW   = cnt_w(DEB_CYCLES);
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = cnt_w(TMAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   hold_q, hold_d;
  logic                   repeat_q, repeat_d;
  hold_state_t            state_q, state_d;

  logic s_c, deb_done_c, rise_c, fall_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      deb_cnt_q <= '0;
      tcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= HS_IDLE;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      tcnt_q    <= tcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], btn_i};
    s_c        = sync_q[SYNC_STAGES-1];
    deb_done_c = (s_c != level_q) && (deb_cnt_q == DW'(DEB_CYCLES - 1));
    rise_c     = deb_done_c && !level_q;
    fall_c     = deb_done_c && level_q;

    level_d   = level_q;
    deb_cnt_d = '0;
    press_d   = rise_c;
    release_d = fall_c;
    hold_d    = 1'b0;
    repeat_d  = 1'b0;
    state_d   = state_q;
    tcnt_d    = tcnt_q;

    // Debounce: count consecutive disagreeing cycles, any agreement restarts.
    if (s_c != level_q) begin
      if (deb_done_c) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end

    // Release wins over any coincident hold/repeat terminal count.
    if (fall_c) begin
      state_d = HS_IDLE;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        HS_IDLE: begin
          if (rise_c) begin
            state_d = HS_PRESSED;
            tcnt_d  = '0;
          end
        end
        HS_PRESSED: begin
          if (tcnt_q == TW'(HOLD_CYCLES - 1)) begin
            hold_d  = 1'b1;
            state_d = HS_HELD;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        HS_HELD: begin
`ifdef INPUT_COND_AUTO_REPEAT_EN
          if (tcnt_q == TW'(REPEAT_CYCLES - 1)) begin
            repeat_d = 1'b1;
            tcnt_d   = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
`else
          tcnt_d = '0;
`endif
        end
        default: begin
          state_d = HS_IDLE;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel button/switch conditioner; replicates input_conditioner_ch per bit.
// Auto-repeat is enabled by defining INPUT_COND_AUTO_REPEAT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned N_CH          = 5,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] hold_o,
  output logic [N_CH-1:0] repeat_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
    $error("input_conditioner: cycle parameters must be >= 1");
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEB_CYCLES   (DEB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .btn_i    (btn_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .hold_o   (hold_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule
